// File: rtl/dds_pkg.sv
// -----------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS sweep controller slice.
//   - DDS_*_WIDTH : default widths of the tuning word, step count and dwell
//   - sweep_state_t : sequencer states
//   - sweep_cfg_t   : sweep descriptor at the default widths
// -----------------------------------------------------------------------------
package dds_pkg;

    localparam int unsigned DDS_TUNE_WIDTH  = 16;
    localparam int unsigned DDS_CNT_WIDTH   = 12;
    localparam int unsigned DDS_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // 'repeat' is a reserved word, hence repeat_en.
    typedef struct packed {
        logic [DDS_TUNE_WIDTH-1:0]  start;
        logic [DDS_TUNE_WIDTH-1:0]  step;
        logic [DDS_CNT_WIDTH-1:0]   steps;
        logic [DDS_DWELL_WIDTH-1:0] dwell;
        logic                       repeat_en;
    } sweep_cfg_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// -----------------------------------------------------------------------------
// dds_dwell_timer
// Loadable down-counter that times how long each tuning word is held.
// Ports:
//   clk      in   system clock, rising edge
//   n_RST    in   asynchronous active-low reset
//   i_load   in   load i_value into the counter this cycle
//   i_value  in   DWELL_WIDTH load value
//   o_zero   out  counter is zero
// Decrements by one per cycle while nonzero and not loading; stops at zero.
// -----------------------------------------------------------------------------
module dds_dwell_timer #(
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   n_RST,
    input  logic                   i_load,
    input  logic [DWELL_WIDTH-1:0] i_value,
    output logic                   o_zero
);

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

    logic [DWELL_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - DWELL_ONE;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
// Drives the DDS phase-accumulator tuning word through a linear sweep.
// A descriptor is accepted over valid/ready, the accumulator is cleared for
// one cycle (PRIME), then each word is held for dwell_eff cycles and stepped
// by a signed increment. Optional repeat restarts from the first word with
// no accumulator clear, so phase stays continuous across restarts.
// Ports:
//   clk, n_RST          clock (rising edge), async active-low reset
//   cfg_valid/cfg_ready descriptor handshake
//   cfg_start           first tuning word
//   cfg_step            per-step increment, two's complement
//   cfg_steps           number of increments (words emitted = steps+1)
//   cfg_dwell           hold cycles per word, 0 behaves as 1
//   cfg_repeat          restart after the last word
//   abort               level-sensitive sweep termination
//   tuning_word         registered word to pa.tuning_word
//   pa_n_rst            active-low synchronous clear request to pa
//   busy                high in PRIME and DWELL
//   step_idx            0-based index of the current word
//   sweep_done          one-cycle pulse at the end of a single sweep
// -----------------------------------------------------------------------------
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned TUNE_WIDTH  = DDS_TUNE_WIDTH,
    parameter int unsigned CNT_WIDTH   = DDS_CNT_WIDTH,
    parameter int unsigned DWELL_WIDTH = DDS_DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   n_RST,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [TUNE_WIDTH-1:0]  cfg_start,
    input  logic [TUNE_WIDTH-1:0]  cfg_step,
    input  logic [CNT_WIDTH-1:0]   cfg_steps,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_repeat,
    input  logic                   abort,
    output logic [TUNE_WIDTH-1:0]  tuning_word,
    output logic                   pa_n_rst,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   step_idx,
    output logic                   sweep_done
);

    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Descriptor held at the parameterised widths for the whole sweep.
    typedef struct packed {
        logic [TUNE_WIDTH-1:0]  start;
        logic [TUNE_WIDTH-1:0]  step;
        logic [CNT_WIDTH-1:0]   steps;
        logic [DWELL_WIDTH-1:0] dwell;
        logic                   repeat_en;
    } cfg_reg_t;

    sweep_state_t           r_state;
    cfg_reg_t               r_cfg;
    logic [TUNE_WIDTH-1:0]  r_tuning_word;
    logic [CNT_WIDTH-1:0]   r_step_idx;
    logic                   r_pa_n_rst;
    logic                   r_cfg_ready;
    logic                   r_busy;
    logic                   r_sweep_done;

    logic                   w_timer_zero;
    logic                   w_timer_load;
    logic [DWELL_WIDTH-1:0] w_timer_value;
    logic [DWELL_WIDTH-1:0] w_dwell_eff;
    logic                   w_last;

    always_comb begin
        w_dwell_eff   = (cfg_dwell == '0) ? DWELL_ONE : cfg_dwell;
        w_last        = (r_step_idx == r_cfg.steps);
        w_timer_value = r_cfg.dwell - DWELL_ONE;
        // Reload on PRIME and whenever DWELL moves on to another word
        // (next step or repeat restart); not when heading to DONE.
        w_timer_load  = 1'b0;
        if (!abort) begin
            if (r_state == PRIME) begin
                w_timer_load = 1'b1;
            end else if (r_state == DWELL && w_timer_zero &&
                         (!w_last || r_cfg.repeat_en)) begin
                w_timer_load = 1'b1;
            end
        end
    end

    dds_dwell_timer #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_timer (
        .clk     (clk),
        .n_RST   (n_RST),
        .i_load  (w_timer_load),
        .i_value (w_timer_value),
        .o_zero  (w_timer_zero)
    );

    always_ff @(posedge clk or negedge n_RST) begin
        if (!n_RST) begin
            r_state       <= IDLE;
            r_cfg         <= '0;
            r_tuning_word <= '0;
            r_step_idx    <= '0;
            r_pa_n_rst    <= 1'b1;
            r_cfg_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_sweep_done  <= 1'b0;
        end else begin
            r_sweep_done <= 1'b0;
            if (abort && r_state != IDLE) begin
                r_state       <= IDLE;
                r_tuning_word <= '0;
                r_step_idx    <= '0;
                r_pa_n_rst    <= 1'b1;
                r_cfg_ready   <= 1'b1;
                r_busy        <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cfg_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_pa_n_rst  <= 1'b1;
                        if (abort) begin
                            r_tuning_word <= '0;
                        end else if (cfg_valid && r_cfg_ready) begin
                            r_cfg.start     <= cfg_start;
                            r_cfg.step      <= cfg_step;
                            r_cfg.steps     <= cfg_steps;
                            r_cfg.dwell     <= w_dwell_eff;
                            r_cfg.repeat_en <= cfg_repeat;
                            r_tuning_word   <= cfg_start;
                            r_step_idx      <= '0;
                            r_pa_n_rst      <= 1'b0;
                            r_cfg_ready     <= 1'b0;
                            r_busy          <= 1'b1;
                            r_state         <= PRIME;
                        end
                    end
                    PRIME: begin
                        r_pa_n_rst <= 1'b1;
                        r_state    <= DWELL;
                    end
                    DWELL: begin
                        if (w_timer_zero) begin
                            if (!w_last) begin
                                r_tuning_word <= r_tuning_word + r_cfg.step;
                                r_step_idx    <= r_step_idx + CNT_ONE;
                            end else if (r_cfg.repeat_en) begin
                                r_tuning_word <= r_cfg.start;
                                r_step_idx    <= '0;
                            end else begin
                                r_busy       <= 1'b0;
                                r_sweep_done <= 1'b1;
                                r_state      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        r_cfg_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tuning_word = r_tuning_word;
    assign pa_n_rst    = r_pa_n_rst;
    assign cfg_ready   = r_cfg_ready;
    assign busy        = r_busy;
    assign step_idx    = r_step_idx;
    assign sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
// Directed bench for dds_sweep_ctrl. Outputs are sampled on the falling edge
// and compared as one packed vector:
//   {tuning_word, step_idx, busy, pa_n_rst, sweep_done, cfg_ready}
// Cycle k in each scenario is the k-th falling edge after the accept edge.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    logic        clk = 1'b0;
    logic        n_RST;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_start;
    logic [15:0] cfg_step;
    logic [11:0] cfg_steps;
    logic [15:0] cfg_dwell;
    logic        cfg_repeat;
    logic        abort;
    logic [15:0] tuning_word;
    logic        pa_n_rst;
    logic        busy;
    logic [11:0] step_idx;
    logic        sweep_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] obs;
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .TUNE_WIDTH  (16),
        .CNT_WIDTH   (12),
        .DWELL_WIDTH (16)
    ) dut (
        .clk         (clk),
        .n_RST       (n_RST),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_start   (cfg_start),
        .cfg_step    (cfg_step),
        .cfg_steps   (cfg_steps),
        .cfg_dwell   (cfg_dwell),
        .cfg_repeat  (cfg_repeat),
        .abort       (abort),
        .tuning_word (tuning_word),
        .pa_n_rst    (pa_n_rst),
        .busy        (busy),
        .step_idx    (step_idx),
        .sweep_done  (sweep_done)
    );

    assign obs = {tuning_word, step_idx, busy, pa_n_rst, sweep_done, cfg_ready};

    function automatic logic [31:0] pack_exp(input logic [15:0] tw, input logic [11:0] idx,
                                             input logic b, input logic p,
                                             input logic d, input logic r);
        return {tw, idx, b, p, d, r};
    endfunction

    task automatic drive_cfg(input sweep_cfg_t c);
        cfg_start  = c.start;
        cfg_step   = c.step;
        cfg_steps  = c.steps;
        cfg_dwell  = c.dwell;
        cfg_repeat = c.repeat_en;
        cfg_valid  = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        exp_v = pack_exp(16'h0000, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", obs, exp_v);
        end
        n_RST = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_basic_sweep;
        sweep_cfg_t  c;
        logic [15:0] w [4];
        w = '{16'h0100, 16'h0110, 16'h0120, 16'h0130};
        c = '{start: 16'h0100, step: 16'h0010, steps: 12'd3, dwell: 16'd4, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            if (k == 1)       exp_v = pack_exp(w[0], 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (k <= 17) exp_v = pack_exp(w[(k-2)/4], 12'((k-2)/4), 1'b1, 1'b1, 1'b0, 1'b0);
            else if (k == 18) exp_v = pack_exp(w[3], 12'd3, 1'b0, 1'b1, 1'b1, 1'b0);
            else              exp_v = pack_exp(w[3], 12'd3, 1'b0, 1'b1, 1'b0, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL basic_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_neg_step_wrap;
        sweep_cfg_t  c;
        logic [15:0] w [5];
        w = '{16'h0008, 16'h0004, 16'h0000, 16'hFFFC, 16'hFFF8};
        c = '{start: 16'h0008, step: 16'hFFFC, steps: 12'd4, dwell: 16'd1, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            if (k == 1)      exp_v = pack_exp(w[0], 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (k <= 6) exp_v = pack_exp(w[k-2], 12'(k-2), 1'b1, 1'b1, 1'b0, 1'b0);
            else if (k == 7) exp_v = pack_exp(w[4], 12'd4, 1'b0, 1'b1, 1'b1, 1'b0);
            else             exp_v = pack_exp(w[4], 12'd4, 1'b0, 1'b1, 1'b0, 1'b1);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL negstep_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_repeat_abort;
        sweep_cfg_t  c;
        logic [15:0] w [2];
        int          j;
        w = '{16'h1000, 16'h1100};
        c = '{start: 16'h1000, step: 16'h0100, steps: 12'd1, dwell: 16'd2, repeat_en: 1'b1};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            j = ((k - 2) / 2) % 2;
            if (k == 1) exp_v = pack_exp(w[0], 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else        exp_v = pack_exp(w[j], 12'(j), 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL repeat_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_v = pack_exp(16'h0000, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL abort_idle_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_dwell_steps;
        sweep_cfg_t c;
        c = '{start: 16'h4242, step: 16'h0001, steps: 12'd0, dwell: 16'd0, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            case (k)
                1:       exp_v = pack_exp(16'h4242, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                2:       exp_v = pack_exp(16'h4242, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
                3:       exp_v = pack_exp(16'h4242, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0);
                default: exp_v = pack_exp(16'h4242, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            endcase
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL zero_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_handshake_corners;
        sweep_cfg_t c;
        // abort together with valid in IDLE: no accept, word forced to 0
        c = '{start: 16'h5555, step: 16'h0001, steps: 12'd2, dwell: 16'd3, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        abort = 1'b1;
        exp_v = pack_exp(16'h0000, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL abort_valid_idle_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
        cfg_valid = 1'b0;
        abort     = 1'b0;

        // valid held high; descriptor changed mid-sweep
        c = '{start: 16'h0200, step: 16'h0001, steps: 12'd1, dwell: 16'd1, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            case (k)
                1:  exp_v = pack_exp(16'h0200, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                2:  exp_v = pack_exp(16'h0200, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
                3:  exp_v = pack_exp(16'h0201, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
                4:  exp_v = pack_exp(16'h0201, 12'd1, 1'b0, 1'b1, 1'b1, 1'b0);
                5:  exp_v = pack_exp(16'h0201, 12'd1, 1'b0, 1'b1, 1'b0, 1'b1);
                6:  exp_v = pack_exp(16'h7777, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                7:  exp_v = pack_exp(16'h7777, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
                8:  exp_v = pack_exp(16'h7877, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
                9:  exp_v = pack_exp(16'h7877, 12'd1, 1'b0, 1'b1, 1'b1, 1'b0);
                default: exp_v = pack_exp(16'h7877, 12'd1, 1'b0, 1'b1, 1'b0, 1'b1);
            endcase
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL hold_valid_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
            if (k == 2) begin
                cfg_start = 16'h7777;
                cfg_step  = 16'h0100;
            end
            if (k == 6) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset;
        sweep_cfg_t c;
        c = '{start: 16'h0300, step: 16'h0001, steps: 12'd3, dwell: 16'd4, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
        end
        exp_v = pack_exp(16'h0301, 12'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL pre_reset_dwell got=%h exp=%h", obs, exp_v);
        end
        #2;
        n_RST = 1'b0;
        #1;
        exp_v = pack_exp(16'h0000, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, exp_v);
        end
        @(negedge clk);
        n_RST = 1'b1;
        c = '{start: 16'h0AAA, step: 16'h0001, steps: 12'd0, dwell: 16'd0, repeat_en: 1'b0};
        @(negedge clk);
        drive_cfg(c);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            case (k)
                1:       exp_v = pack_exp(16'h0AAA, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
                2:       exp_v = pack_exp(16'h0AAA, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
                3:       exp_v = pack_exp(16'h0AAA, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0);
                default: exp_v = pack_exp(16'h0AAA, 12'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            endcase
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL post_reset_cyc%0d got=%h exp=%h", k, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_RST      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_start  = '0;
        cfg_step   = '0;
        cfg_steps  = '0;
        cfg_dwell  = '0;
        cfg_repeat = 1'b0;
        abort      = 1'b0;

        test_reset();
        test_basic_sweep();
        test_neg_step_wrap();
        test_repeat_abort();
        test_zero_dwell_steps();
        test_handshake_corners();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
